// File: rtl/add_sub_cs_unit_if.sv
// Operand/result bundle for the registered carry-select add/subtract unit.
// The master drives the operation; the slave (the unit) returns the result.
interface add_sub_cs_unit_if;
  logic        sub;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        cin;
  logic [15:0] out;
  logic        cout;
  logic        invalid;

  modport master (output sub, in1, in2, cin, input out, cout, invalid);
  modport slave  (input sub, in1, in2, cin, output out, cout, invalid);
endinterface

// File: rtl/add_sub_cs.sv
// Registered 16-bit self-describing fixed-point add/subtract.
// Each word is {F[2:0], M[12:0]}, with value = M / 2^F.
// Operands are aligned to the larger F and then summed in a carry-select mantissa adder.
// The overflow check uses a separate full-precision sum.

// One carry-select block.
// The lowest block ripples directly from its carry-in.
// Upper blocks precompute sums for cin=0 and cin=1 and select one when the carry arrives.
module add_sub_cs_block #(
  parameter int W    = 4,
  parameter bit DUAL = 1'b1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  if (DUAL) begin : g_dual
    logic [W:0] sum0, sum1;
    // Both candidate sums are formed in parallel; the late carry only drives the mux.
    always_comb begin
      sum0 = {1'b0, a} + {1'b0, b};
      sum1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
    end
    assign {co, s} = ci ? sum1 : sum0;
  end else begin : g_ripple
    logic [W:0] sum;
    // Plain ripple block fed directly by the adder carry-in.
    always_comb begin
      sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    end
    assign {co, s} = sum;
  end
endmodule

// Top level: alignment, carry-select mantissa adder, overflow detect, output register.
module add_sub_cs_unit #(
  parameter int BLOCK_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  add_sub_cs_unit_if.slave   bus
);
  localparam int MW   = 13;
  localparam int NBLK = (MW + BLOCK_W - 1) / BLOCK_W;
  localparam int PW   = NBLK * BLOCK_W;

  logic [2:0]    fa, fb, fr, sha, shb;
  logic [21:0]   a_ext, b_ext;
  logic [22:0]   r_full;
  logic          c0;
  logic [PW-1:0] opa, opb, sum;
  logic [NBLK:0] carry;
  logic [PW:0]   sum_ext;

  logic [15:0]   out_d, out_q;
  logic          cout_d, cout_q;
  logic          invalid_d, invalid_q;
  logic          unused_bits;

  // Align both mantissas to the larger fraction count and form the adder operands.
  // Subtract inverts B and the carry, so a - b - cin equals a + ~b + ~cin.
  always_comb begin
    fa    = bus.in1[15:13];
    fb    = bus.in2[15:13];
    fr    = (fa > fb) ? fa : fb;
    sha   = fr - fa;
    shb   = fr - fb;
    a_ext = {{9{bus.in1[12]}}, bus.in1[12:0]} << sha;
    b_ext = {{9{bus.in2[12]}}, bus.in2[12:0]} << shb;
    c0    = bus.sub ^ bus.cin;
    opa   = '0;
    opb   = '0;
    opa[MW-1:0] = a_ext[MW-1:0];
    opb[MW-1:0] = b_ext[MW-1:0] ^ {MW{bus.sub}};
    // The full-width sum keeps every shifted bit, so alignment overflow shows up here too.
    r_full = {a_ext[21], a_ext} + ({b_ext[21], b_ext} ^ {23{bus.sub}}) + {22'd0, c0};
  end

  assign carry[0] = c0;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    add_sub_cs_block #(.W(BLOCK_W), .DUAL(g != 0)) u_blk (
      .a  (opa[g*BLOCK_W +: BLOCK_W]),
      .b  (opb[g*BLOCK_W +: BLOCK_W]),
      .ci (carry[g]),
      .s  (sum[g*BLOCK_W +: BLOCK_W]),
      .co (carry[g+1])
    );
  end

  // Mantissa wraps to 13 bits.
  // cout is the carry out of bit 12; zero-padded upper bits simply pass it up.
  // The result is invalid unless the true result fits a 13-bit signed mantissa.
  always_comb begin
    sum_ext   = {carry[NBLK], sum};
    out_d     = {fr, sum_ext[MW-1:0]};
    cout_d    = sum_ext[MW];
    invalid_d = ~((&r_full[22:12]) | ~(|r_full[22:12]));
  end

  assign unused_bits = ^{sum_ext, r_full[11:0]};

  // Output register; synchronous reset wins over the incoming operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= 16'h0000;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.cout    = cout_q;
  assign bus.invalid = invalid_q;
endmodule

// File: tb/tb_add_sub_cs_unit.sv
// Scoreboard bench for add_sub_cs_unit.
// The driver pushes the expected result for every issued cycle.
// The monitor pops and compares one cycle later.
module tb_add_sub_cs_unit;
  typedef struct {
    logic [15:0] out;
    logic        cout;
    logic        invalid;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_vld = 1'b0;
  logic mon_v;
  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;

  add_sub_cs_unit_if bus ();

  add_sub_cs_unit #(.BLOCK_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [15:0] o, input logic c, input logic inv, input string nm);
    exp_t r;
    r.out = o; r.cout = c; r.invalid = inv; r.name = nm;
    return r;
  endfunction

  // Reference: integer arithmetic on aligned values, straight from the operand definition.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c);
    exp_t r;
    int fa, fb, fr, ma, mb, ap, bp, rr, ua, ub, t;
    logic [31:0] tv, rv;
    fa = int'(a[15:13]);
    fb = int'(b[15:13]);
    fr = (fa > fb) ? fa : fb;
    ma = int'($signed(a[12:0]));
    mb = int'($signed(b[12:0]));
    ap = ma * (1 << (fr - fa));
    bp = mb * (1 << (fr - fb));
    rr = s ? (ap - bp - int'(c)) : (ap + bp + int'(c));
    ua = ap & 32'h1FFF;
    ub = (s ? ~bp : bp) & 32'h1FFF;
    t  = ua + ub + int'(s ? ~c : c);
    tv = t;
    rv = rr;
    r.out = {3'(fr), rv[12:0]};
    r.cout = tv[13];
    r.invalid = (rr < -4096) || (rr > 4095);
    r.name = "random";
    return r;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic c, input logic r, input exp_t ex);
    @(negedge clk);
    bus.in1 = a; bus.in2 = b; bus.sub = s; bus.cin = c;
    rst_n = r;
    tb_vld = 1'b1;
    q.push_back(ex);
  endtask

  // Monitor: an operation issued before edge N is checked just after edge N.
  always @(posedge clk) begin
    mon_v = tb_vld;
    #1;
    if (mon_v) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: output seen with no expected entry");
      end else begin
        e = q.pop_front();
        if (bus.out !== e.out || bus.cout !== e.cout || bus.invalid !== e.invalid) begin
          n_fail++;
          $display("FAIL %s: got out=%h cout=%b invalid=%b, want out=%h cout=%b invalid=%b",
                   e.name, bus.out, bus.cout, bus.invalid, e.out, e.cout, e.invalid);
        end
      end
    end
  end

  initial begin
    logic [12:0] ma, mb;
    logic        s, c;
    logic [15:0] a, b;
    bus.in1 = '0; bus.in2 = '0; bus.sub = 1'b0; bus.cin = 1'b0;

    // Reset state, with nonzero inputs present that must be ignored.
    issue(16'h848D, 16'h614A, 1'b0, 1'b0, 1'b0, mk(16'h0000, 1'b0, 1'b0, "reset0"));
    issue(16'h848D, 16'hE14A, 1'b0, 1'b1, 1'b0, mk(16'h0000, 1'b0, 1'b0, "reset1"));

    // Directed vectors, back to back.
    issue(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1, mk(16'h0005, 1'b0, 1'b0, "add_int"));
    issue(16'h0002, 16'h0003, 1'b0, 1'b1, 1'b1, mk(16'h0006, 1'b0, 1'b0, "add_cin"));
    issue(16'h0006, 16'h0003, 1'b1, 1'b0, 1'b1, mk(16'h0003, 1'b1, 1'b0, "sub_int"));
    issue(16'h848D, 16'h614A, 1'b0, 1'b0, 1'b1, mk(16'h8721, 1'b0, 1'b0, "align_add"));
    issue(16'h848D, 16'h614A, 1'b1, 1'b0, 1'b1, mk(16'h81F9, 1'b1, 1'b0, "align_sub"));
    issue(16'h848D, 16'hE14A, 1'b0, 1'b0, 1'b1, mk(16'hE5B2, 1'b0, 1'b1, "overflow"));
    issue(16'h8495, 16'h7C4A, 1'b0, 1'b0, 1'b1, mk(16'h9D29, 1'b0, 1'b0, "neg_add"));
    issue(16'h8495, 16'h7C4A, 1'b1, 1'b0, 1'b1, mk(16'h8C01, 1'b0, 1'b0, "neg_sub"));
    issue(16'hBC97, 16'h3F4B, 1'b0, 1'b0, 1'b1, mk(16'hB147, 1'b1, 1'b0, "neg_neg_add"));
    // Edges of the 13-bit range at F=0: 4095 fits, 4095+1 does not, -4096 fits, -4096-1 does not.
    issue(16'h0FFE, 16'h0000, 1'b0, 1'b1, 1'b1, mk(16'h0FFF, 1'b0, 1'b0, "max_pos"));
    issue(16'h0FFF, 16'h0000, 1'b0, 1'b1, 1'b1, mk(16'h1000, 1'b0, 1'b1, "pos_ovf"));
    issue(16'h1000, 16'h0000, 1'b1, 1'b0, 1'b1, mk(16'h1000, 1'b1, 1'b0, "min_neg"));
    issue(16'h1000, 16'h0000, 1'b1, 1'b1, 1'b1, mk(16'h0FFF, 1'b1, 1'b1, "neg_ovf"));

    // Mid-stream reset discards the operation sampled with rst_n low.
    issue(16'h848D, 16'h614A, 1'b0, 1'b0, 1'b1, mk(16'h8721, 1'b0, 1'b0, "pre_reset"));
    issue(16'h848D, 16'hE14A, 1'b0, 1'b0, 1'b0, mk(16'h0000, 1'b0, 1'b0, "mid_reset"));
    issue(16'h8495, 16'h7C4A, 1'b1, 1'b0, 1'b1, mk(16'h8C01, 1'b0, 1'b0, "post_reset"));

    // Randomized sweep over every F pair.
    for (int fa = 0; fa < 8; fa++) begin
      for (int fb = 0; fb < 8; fb++) begin
        for (int k = 0; k < 2; k++) begin
          ma = 13'($urandom);
          mb = 13'($urandom);
          s  = 1'($urandom);
          c  = 1'($urandom);
          a  = {3'(fa), ma};
          b  = {3'(fb), mb};
          issue(a, b, s, c, 1'b1, model(a, b, s, c));
        end
      end
    end

    @(negedge clk);
    tb_vld = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected results left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
